multicycle_control_unit: RTL
============================

// Module: multicycle_control_unit
// PURPOSE
//  Multi-cycle successor of the single-cycle opcode decoder: sequences each instruction through
//  FETCH/DECODE/EXEC/MEM/WB, handshaking with instruction and data memories that may insert wait states.
//  Sits between the IR/opcode field and the datapath (ALU, reg file, PC, data memory); same control set plus fetch/PC strobes.
// PARAMETERS
//  OPCODE_W        4    opcode field width; opcodes >= 4'b0111 (zero-extended) decode as JUMP
//  TIMEOUT_CYCLES  16   max wait cycles per memory access (used only with MEM_TIMEOUT_EN), >= 1
// PORTS
//  clk            in   1         rising-edge clock
//  reset          in   1         synchronous, active-high
//  opcode         in   OPCODE_W  opcode field from IR, valid in DECODE
//  stall          in   1         hold off new instruction (sampled in FETCH only)
//  instrReady     in   1         instruction memory data valid / accept
//  dataReady      in   1         data memory read data valid / write accepted
//  instrMemRead   out  1         instruction fetch request
//  irWrite        out  1         load IR (Mealy: FETCH && instrReady && !stall)
//  pcWrite        out  1         PC write strobe (increment at fetch, target in EXEC of JUMP)
//  dataMemRead    out  1         data memory read request
//  dataMemWrite   out  1         data memory write request
//  regWrite       out  1         register file write enable
//  immediate      out  1         ALU B-operand = immediate
//  ALUand         out  1         ALU AND select
//  ALUadd         out  1         ALU ADD select
//  comparator     out  1         comparator enable
//  PCselect       out  1         PC mux = jump target
//  instrDone      out  1         1-cycle pulse in final cycle of each instruction
//  memTimeout     out  1         1-cycle pulse on abandoned access (0 without MEM_TIMEOUT_EN)
//  state          out  3         current FSM state (debug)
// BEHAVIOUR
//  - reset high: next state FETCH, opReg=0, wait counter=0; ALL outputs forced 0 while reset high,
//    regardless of state (reset mid-MEM drops request same cycle, no regWrite).
//  - Opcodes: 0000 ADD, 0001 ADDI, 0010 AND, 0011 ANDI, 0100 LD, 0101 ST, 0110 CMP, else JUMP.
//  - FETCH: stall=1 -> all outputs 0, stay. Else instrMemRead=1 held until instrReady; on instrReady
//    irWrite=1, pcWrite=1 same cycle, -> DECODE. Ready in same cycle as request start is accepted.
//  - DECODE (1 cycle): opReg <= opcode; no outputs asserted; -> EXEC.
//  - EXEC (1 cycle), Moore from opReg: ADD ALUadd; ADDI ALUadd+immediate; AND ALUand; ANDI ALUand+immediate;
//    CMP comparator, instrDone; JUMP PCselect+pcWrite, instrDone; LD/ST none.
//    Next: ALU ops -> WB; LD/ST -> MEM; CMP/JUMP -> FETCH.
//  - MEM: LD dataMemRead=1, ST dataMemWrite=1, held until dataReady; LD -> WB, ST -> FETCH (instrDone on ready cycle).
//  - WB (1 cycle): regWrite=1, ALU selects of EXEC held stable; LD: ALU selects 0; instrDone; -> FETCH.
//  - instrReady/dataReady outside their wait state ignored. stall ignored outside FETCH.
//  - Zero-wait latency (cycles incl. FETCH): ALU op 4, LD 5, ST 4, CMP 3, JUMP 3; +1 per wait cycle.
//  - Exactly one of dataMemRead/dataMemWrite/regWrite-in-MEM ever high; requests never overlap.
// CONFIGURATION
//  - MEM_TIMEOUT_EN defined: counter counts cycles a request (FETCH not stalled, or MEM) waits without ready;
//    cleared on state change; on reaching TIMEOUT_CYCLES with ready still 0: drop request, memTimeout=1 for
//    that cycle, -> FETCH, no irWrite/pcWrite/regWrite, no instrDone. Ready on the limit cycle wins over timeout.
//  - Undefined: waits indefinitely; no counter logic; memTimeout tied 0.
// STRUCTURE
//  - control_pkg: opcode localparams (OP_ADD..OP_CMP), state encodings (S_FETCH=0,S_DECODE=1,S_EXEC=2,
//    S_MEM=3,S_WB=4), 3-bit state width.
//  - Sub-module control_decode: combinational opReg -> {immediate,ALUand,ALUadd,comparator,PCselect,isMem,isLoad}.
//  - Top: state register, opReg, optional wait counter, output gating.
// TESTING
//  - Reset mid-MEM of LD (dataReady=0): reset=1 -> all outputs 0 that cycle; after release state=0, instrMemRead=1.
//  - ADDI 0001, zero waits: irWrite@c0, EXEC@c2 ALUadd=immediate=1, WB@c3 regWrite=1, instrDone@c3.
//  - LD 0100, dataReady after 3 wait cycles: dataMemRead high 4 cycles, then WB regWrite=1; total 8 cycles.
//  - JUMP 1111: EXEC PCselect=1, pcWrite=1, instrDone=1, next cycle FETCH; regWrite never 1.
//  - stall=1 for 5 cycles in FETCH with instrReady=1: no irWrite/instrMemRead; stall=0 -> irWrite same cycle.
//  - MEM_TIMEOUT_EN, TIMEOUT_CYCLES=4, ST with dataReady=0: memTimeout pulse after 4 wait cycles, back to FETCH,
//    instrDone=0; repeat with dataReady on 4th cycle -> normal completion, memTimeout=0.

Source files
------------

// File: rtl/multicycle_control_unit_pkg.sv
// Shared encodings for the multi-cycle control unit: opcodes, FSM states, state width.
package multicycle_control_unit_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_ADDI = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_ANDI = 4'b0011;
  localparam logic [3:0] OP_LD   = 4'b0100;
  localparam logic [3:0] OP_ST   = 4'b0101;
  localparam logic [3:0] OP_CMP  = 4'b0110;

endpackage

// File: rtl/multicycle_control_unit_if.sv
// Control-unit <-> IR/memory/datapath signal bundle; master is the control unit.
interface multicycle_control_unit_if
  import multicycle_control_unit_pkg::*;
#(
  parameter int OPCODE_W = 4
);

  logic [OPCODE_W-1:0] opcode;
  logic                stall;
  logic                instrReady;
  logic                dataReady;
  logic                instrMemRead;
  logic                irWrite;
  logic                pcWrite;
  logic                dataMemRead;
  logic                dataMemWrite;
  logic                regWrite;
  logic                immediate;
  logic                ALUand;
  logic                ALUadd;
  logic                comparator;
  logic                PCselect;
  logic                instrDone;
  logic                memTimeout;
  logic [STATE_W-1:0]  state;

  modport master (
    input  opcode, stall, instrReady, dataReady,
    output instrMemRead, irWrite, pcWrite, dataMemRead, dataMemWrite, regWrite,
           immediate, ALUand, ALUadd, comparator, PCselect, instrDone, memTimeout, state
  );

  modport slave (
    output opcode, stall, instrReady, dataReady,
    input  instrMemRead, irWrite, pcWrite, dataMemRead, dataMemWrite, regWrite,
           immediate, ALUand, ALUadd, comparator, PCselect, instrDone, memTimeout, state
  );

endinterface

// File: rtl/multicycle_control_unit_decode.sv
// Combinational opcode decode: latched opcode -> ALU/PC selects and memory class.
module multicycle_control_unit_decode
  import multicycle_control_unit_pkg::*;
#(
  parameter int OPCODE_W = 4
) (
  input  logic [OPCODE_W-1:0] i_op,
  output logic                o_immediate,
  output logic                o_alu_and,
  output logic                o_alu_add,
  output logic                o_comparator,
  output logic                o_pc_select,
  output logic                o_is_mem,
  output logic                o_is_load
);

  // Zero-extend to at least 4 bits so every opcode at or above 4'b0111 falls into JUMP.
  localparam int CW = (OPCODE_W > 4) ? OPCODE_W : 4;

  logic [CW-1:0] w_op;
  assign w_op = CW'(i_op);

  always_comb begin
    o_immediate  = 1'b0;
    o_alu_and    = 1'b0;
    o_alu_add    = 1'b0;
    o_comparator = 1'b0;
    o_pc_select  = 1'b0;
    o_is_mem     = 1'b0;
    o_is_load    = 1'b0;
    case (w_op)
      CW'(OP_ADD):  o_alu_add = 1'b1;
      CW'(OP_ADDI): begin o_alu_add = 1'b1; o_immediate = 1'b1; end
      CW'(OP_AND):  o_alu_and = 1'b1;
      CW'(OP_ANDI): begin o_alu_and = 1'b1; o_immediate = 1'b1; end
      CW'(OP_LD):   begin o_is_mem = 1'b1; o_is_load = 1'b1; end
      CW'(OP_ST):   o_is_mem = 1'b1;
      CW'(OP_CMP):  o_comparator = 1'b1;
      default:      o_pc_select = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// FETCH/DECODE/EXEC/MEM/WB sequencer with memory wait states.
// Define MEM_TIMEOUT_EN to abandon accesses that wait TIMEOUT_CYCLES without ready.
module multicycle_control_unit
  import multicycle_control_unit_pkg::*;
#(
  parameter int OPCODE_W       = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  multicycle_control_unit_if.master  bus
);

  state_t              r_state, w_state_next;
  logic [OPCODE_W-1:0] r_op;

  logic w_imm, w_alu_and, w_alu_add, w_cmp, w_pcs, w_is_mem, w_is_load;
  logic w_imr, w_irw, w_pcw, w_dmr, w_dmw, w_rw;
  logic w_imm_o, w_and_o, w_add_o, w_cmp_o, w_pcs_o, w_done, w_mto;
  logic w_timeout;

  multicycle_control_unit_decode #(.OPCODE_W(OPCODE_W)) u_decode (
    .i_op         (r_op),
    .o_immediate  (w_imm),
    .o_alu_and    (w_alu_and),
    .o_alu_add    (w_alu_add),
    .o_comparator (w_cmp),
    .o_pc_select  (w_pcs),
    .o_is_mem     (w_is_mem),
    .o_is_load    (w_is_load)
  );

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] r_wait_cnt, w_wait_cnt_next;
  logic             w_waiting;

  // A request is waiting when it is asserted and its ready has not come back this cycle.
  assign w_waiting = ((r_state == S_FETCH) && !bus.stall && !bus.instrReady) ||
                     ((r_state == S_MEM) && !bus.dataReady);
  assign w_timeout = w_waiting && (r_wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    w_wait_cnt_next = '0;
    if (w_waiting && !w_timeout)
      w_wait_cnt_next = r_wait_cnt + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) r_wait_cnt <= '0;
    else       r_wait_cnt <= w_wait_cnt_next;
  end
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT_CYCLES > 0);
  assign w_timeout        = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_FETCH;
      r_op    <= '0;
    end else begin
      r_state <= w_state_next;
      if (r_state == S_DECODE) r_op <= bus.opcode;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_imr   = 1'b0;
    w_irw   = 1'b0;
    w_pcw   = 1'b0;
    w_dmr   = 1'b0;
    w_dmw   = 1'b0;
    w_rw    = 1'b0;
    w_imm_o = 1'b0;
    w_and_o = 1'b0;
    w_add_o = 1'b0;
    w_cmp_o = 1'b0;
    w_pcs_o = 1'b0;
    w_done  = 1'b0;
    w_mto   = 1'b0;
    case (r_state)
      S_FETCH: begin
        if (!bus.stall) begin
          w_imr = 1'b1;
          if (bus.instrReady) begin
            w_irw        = 1'b1;
            w_pcw        = 1'b1;
            w_state_next = S_DECODE;
          end else if (w_timeout) begin
            w_mto = 1'b1;
          end
        end
      end
      S_DECODE: w_state_next = S_EXEC;
      S_EXEC: begin
        w_imm_o = w_imm;
        w_and_o = w_alu_and;
        w_add_o = w_alu_add;
        w_cmp_o = w_cmp;
        w_pcs_o = w_pcs;
        w_pcw   = w_pcs;
        w_done  = w_cmp | w_pcs;
        if (w_is_mem)           w_state_next = S_MEM;
        else if (w_cmp | w_pcs) w_state_next = S_FETCH;
        else                    w_state_next = S_WB;
      end
      S_MEM: begin
        w_dmr = w_is_load;
        w_dmw = !w_is_load;
        if (bus.dataReady) begin
          w_done       = !w_is_load;
          w_state_next = w_is_load ? S_WB : S_FETCH;
        end else if (w_timeout) begin
          w_mto        = 1'b1;
          w_state_next = S_FETCH;
        end
      end
      S_WB: begin
        // EXEC's ALU selects stay up so the result is stable while it is written back.
        w_rw         = 1'b1;
        w_imm_o      = w_imm;
        w_and_o      = w_alu_and;
        w_add_o      = w_alu_add;
        w_done       = 1'b1;
        w_state_next = S_FETCH;
      end
      default: w_state_next = S_FETCH;
    endcase
    if (reset) begin
      w_imr   = 1'b0;
      w_irw   = 1'b0;
      w_pcw   = 1'b0;
      w_dmr   = 1'b0;
      w_dmw   = 1'b0;
      w_rw    = 1'b0;
      w_imm_o = 1'b0;
      w_and_o = 1'b0;
      w_add_o = 1'b0;
      w_cmp_o = 1'b0;
      w_pcs_o = 1'b0;
      w_done  = 1'b0;
      w_mto   = 1'b0;
    end
  end

  assign bus.instrMemRead = w_imr;
  assign bus.irWrite      = w_irw;
  assign bus.pcWrite      = w_pcw;
  assign bus.dataMemRead  = w_dmr;
  assign bus.dataMemWrite = w_dmw;
  assign bus.regWrite     = w_rw;
  assign bus.immediate    = w_imm_o;
  assign bus.ALUand       = w_and_o;
  assign bus.ALUadd       = w_add_o;
  assign bus.comparator   = w_cmp_o;
  assign bus.PCselect     = w_pcs_o;
  assign bus.instrDone    = w_done;
  assign bus.memTimeout   = w_mto;
  assign bus.state        = reset ? '0 : r_state;

endmodule
